// File: rtl/im_loader.sv
// Program loader for the instruction memory.
// Takes a length-prefixed byte stream over valid/ready and packs it into 32-bit words.
// Writes each word to the IM write port and checks a trailing XOR checksum.
// Holds the CPU in reset until a load finishes with a good checksum.
module im_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              IM_enable,
  output logic              IM_write,
  output logic [ADDR_W-1:0] IM_address,
  output logic [31:0]       IM_in,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  // One extra bit so a full-depth load reaches N without wrapping.
  localparam int unsigned IdxW = ADDR_W + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLenHi = 3'd1;
  localparam logic [2:0] StLenLo = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StCsum  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;
  localparam logic [2:0] StErr   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        csum_q, csum_d;
  // Only the first three bytes of a word need holding; the fourth arrives with the write.
  logic [23:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept;
  logic [15:0]       len_w;
  logic [IdxW-1:0]   idx_inc;

  assign accept  = in_valid & in_ready;
  assign len_w   = {len_hi_q, in_data};
  assign idx_inc = idx_q + {{(IdxW-1){1'b0}}, 1'b1};

  // Output decode from the registered state; write address/data hold after the strobe.
  always_comb begin
    in_ready   = (state_q == StLenHi) || (state_q == StLenLo) ||
                 (state_q == StData)  || (state_q == StCsum);
    IM_write   = (state_q == StWrite);
    IM_enable  = (state_q == StWrite);
    IM_address = addr_q;
    IM_in      = wdata_q;
    cpu_rst    = (state_q != StDone);
    done       = (state_q == StDone);
    error      = (state_q == StErr);
  end

  // Next-state logic: stream parsing, word assembly and checksum accumulation.
  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StLenHi;
      end
      StLenHi: begin
        if (accept) begin
          len_hi_d = in_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = len_w;
          if (len_w == 16'd0 || 32'(len_w) > DEPTH) begin
            state_d = StErr;
          end else begin
            idx_d      = '0;
            csum_d     = '0;
            byte_cnt_d = '0;
            state_d    = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d     = {word_q[15:0], in_data};
          csum_d     = csum_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            addr_d  = idx_q[ADDR_W-1:0];
            wdata_d = {word_q, in_data};
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        idx_d   = idx_inc;
        state_d = (32'(idx_inc) == 32'(len_q)) ? StCsum : StData;
      end
      StCsum: begin
        if (accept) state_d = (in_data == csum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      len_hi_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule
